pipe_stage_skid_reg: RTL and testbench
======================================

Name: pipe_stage_skid_reg

Overview:
- Parametrised pipeline stage register that succeeds the fixed per-stage registers (FD/DE/EM/MW).
- Carries an opaque payload plus the hazard-unit fields: destination register `a3` and countdown `tnew`.
- Adds a valid/ready handshake backed by a 2-entry skid buffer, so a stall does not have to propagate combinationally upstream.
- Includes a synchronous flush input for exception/interrupt requests (`Req`) and branch kills.
- Instantiated between any two pipeline stages.

Parameters:
- DW, 128, payload width in bits (PC, Instr, results etc. concatenated by the instantiating stage).
- TW, 2, width of the `tnew` field.
- A3W, 5, width of the destination-register field.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-low reset; sampled on rising edge of clk; 0 clears all state.
- flush  input  1  synchronous kill of all held entries; active high.
- in_valid  input  1  upstream stage presents a valid entry.
- in_ready  output  1  stage can accept an entry this cycle.
- in_data  input  DW  payload.
- in_a3  input  A3W  destination register of the incoming entry.
- in_tnew  input  TW  Tnew of the incoming entry, as seen by the upstream stage.
- out_valid  output  1  main register holds a valid entry.
- out_ready  input  1  downstream stage consumes the entry this cycle.
- out_data  output  DW  payload of the main register.
- out_a3  output  A3W  destination register for forwarding/stall logic; 0 when out_valid=0.
- out_tnew  output  TW  Tnew of the main entry; 0 when out_valid=0.
- occupancy  output  2  number of valid entries held (0, 1 or 2).

Behaviour:
- Storage: main register (drives the outputs) plus skid register, each with a valid bit. States are EMPTY (0 entries), ONE (main valid), TWO (main and skid valid).
- in_ready = (state != TWO). It is a registered decode with no combinational path from out_ready.
- Transfer in: in_valid & in_ready. Transfer out: out_valid & out_ready.
- Load rule: every entry written from the input stores tnew_sat = (in_tnew==0) ? 0 : in_tnew-1. Decrement-on-capture is identical for main and skid. a3 and data are stored unchanged.
- EMPTY:
  - in_valid -> load main; go to ONE.
  - else stay.
- ONE:
  - out_ready & in_valid -> main <= input; stay ONE.
  - out_ready & !in_valid -> go to EMPTY.
  - !out_ready & in_valid -> skid <= input; go to TWO.
  - otherwise hold.
- TWO:
  - in_ready=0; input is ignored.
  - out_ready -> main <= skid (fields copied unchanged, no further decrement); go to ONE.
  - otherwise hold.
- Ordering: entries leave in arrival order; no entry is dropped or duplicated except by flush or reset.
- Flush:
  - All valid bits cleared and state goes to EMPTY on the same edge.
  - Has priority over any simultaneous transfer; an input offered in the flush cycle is discarded.
  - in_ready stays 1 in the flush cycle (entry accepted-and-killed).
- Reset (reset==0): state EMPTY; out_valid=0, out_data=0, out_a3=0, out_tnew=0, occupancy=0, in_ready=1; skid contents zeroed. Reset takes priority over flush. Reset mid-TWO discards both entries.
- On flush, data registers hold stale contents but out_data is masked to 0 while out_valid=0. out_a3 and out_tnew are always masked when invalid, so bubbles never forward or stall.
- Latency:
  - 1 cycle in->out when the stage is empty or draining.
  - Throughput 1 entry/cycle sustained while out_ready=1.
- occupancy updates on the same edge as state.

Optional Feature:
- Macro PIPE_STAGE_TNEW_AGE_EN.
- Defined: every cycle an entry is held without leaving its register (main not consumed, or skid not promoted), its stored tnew decrements, saturating at 0. Promotion from skid to main also decrements once. This models elapsed cycles while stalled.
- Undefined: tnew decrements only at capture, as in the Load rule; held entries keep their value.

Test Plan:
- Reset at reset=0 for 2 cycles, then in_valid=1, in_a3=5, in_tnew=2, out_ready=1 -> next cycle out_valid=1, out_a3=5, out_tnew=1; before that all outputs 0 and occupancy=0.
- Stream 8 entries (data=i, tnew=0) with out_ready=1 -> out_data 0..7 on consecutive cycles, out_tnew=0, in_ready never 0.
- Backpressure: out_ready=0, send entries A and B -> occupancy=2, in_ready=0. Entry C is held upstream. out_ready=1 -> A, B, C emitted in order, no loss.
- Flush in state TWO with in_valid=1 -> next cycle out_valid=0, out_a3=0, occupancy=0, in_ready=1. The offered entry never appears.
- Reset (reset=0) asserted simultaneously with flush and in_valid while occupancy=1 -> all outputs 0 next cycle.
- With PIPE_STAGE_TNEW_AGE_EN: capture tnew=3 (TW=2), hold out_ready=0 for 3 cycles -> out_tnew goes 2, 1, 0, 0. Without the macro it stays 2.

Source files
------------

// File: rtl/pipe_stage_skid_reg_if.sv
// Handshake bundle for pipe_stage_skid_reg: upstream valid/ready in, downstream valid/ready out.
// master = surrounding stages, slave = the stage register itself.
interface pipe_stage_skid_reg_if #(
    parameter int DW  = 128,
    parameter int TW  = 2,
    parameter int A3W = 5
);
    logic           in_valid;
    logic           in_ready;
    logic [DW-1:0]  in_data;
    logic [A3W-1:0] in_a3;
    logic [TW-1:0]  in_tnew;
    logic           out_valid;
    logic           out_ready;
    logic [DW-1:0]  out_data;
    logic [A3W-1:0] out_a3;
    logic [TW-1:0]  out_tnew;

    modport master (
        output in_valid, in_data, in_a3, in_tnew, out_ready,
        input  in_ready, out_valid, out_data, out_a3, out_tnew
    );

    modport slave (
        input  in_valid, in_data, in_a3, in_tnew, out_ready,
        output in_ready, out_valid, out_data, out_a3, out_tnew
    );
endinterface

// File: rtl/pipe_stage_skid_reg.sv
// Pipeline stage register with 2-entry skid buffer, flush and hazard fields (a3, tnew).
// Define PIPE_STAGE_TNEW_AGE_EN to age stored tnew while entries are stalled.
module pipe_stage_skid_reg #(
    parameter int DW  = 128,
    parameter int TW  = 2,
    parameter int A3W = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    pipe_stage_skid_reg_if.slave  bus,
    output logic [1:0]            occupancy
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [DW-1:0]  main_data_q, main_data_d;
    logic [A3W-1:0] main_a3_q, main_a3_d;
    logic [TW-1:0]  main_tnew_q, main_tnew_d;
    logic [DW-1:0]  skid_data_q, skid_data_d;
    logic [A3W-1:0] skid_a3_q, skid_a3_d;
    logic [TW-1:0]  skid_tnew_q, skid_tnew_d;
    logic [TW-1:0]  in_tnew_sat;

    function automatic logic [TW-1:0] dec_sat(input logic [TW-1:0] v);
        return (v == '0) ? '0 : v - 1'b1;
    endfunction

    // Applied to every entry that stays put for a cycle, and to skid->main promotion.
    function automatic logic [TW-1:0] age(input logic [TW-1:0] v);
`ifdef PIPE_STAGE_TNEW_AGE_EN
        return dec_sat(v);
`else
        return v;
`endif
    endfunction

    assign in_tnew_sat = dec_sat(bus.in_tnew);

    always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        main_a3_d   = main_a3_q;
        main_tnew_d = main_tnew_q;
        skid_data_d = skid_data_q;
        skid_a3_d   = skid_a3_q;
        skid_tnew_d = skid_tnew_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (bus.in_valid) begin
                        main_data_d = bus.in_data;
                        main_a3_d   = bus.in_a3;
                        main_tnew_d = in_tnew_sat;
                        state_d     = ONE;
                    end
                end
                ONE: begin
                    if (bus.out_ready) begin
                        if (bus.in_valid) begin
                            main_data_d = bus.in_data;
                            main_a3_d   = bus.in_a3;
                            main_tnew_d = in_tnew_sat;
                        end else begin
                            state_d = EMPTY;
                        end
                    end else begin
                        main_tnew_d = age(main_tnew_q);
                        if (bus.in_valid) begin
                            skid_data_d = bus.in_data;
                            skid_a3_d   = bus.in_a3;
                            skid_tnew_d = in_tnew_sat;
                            state_d     = TWO;
                        end
                    end
                end
                TWO: begin
                    if (bus.out_ready) begin
                        main_data_d = skid_data_q;
                        main_a3_d   = skid_a3_q;
                        main_tnew_d = age(skid_tnew_q);
                        state_d     = ONE;
                    end else begin
                        main_tnew_d = age(main_tnew_q);
                        skid_tnew_d = age(skid_tnew_q);
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= EMPTY;
            main_data_q <= '0;
            main_a3_q   <= '0;
            main_tnew_q <= '0;
            skid_data_q <= '0;
            skid_a3_q   <= '0;
            skid_tnew_q <= '0;
        end else begin
            state_q     <= state_d;
            main_data_q <= main_data_d;
            main_a3_q   <= main_a3_d;
            main_tnew_q <= main_tnew_d;
            skid_data_q <= skid_data_d;
            skid_a3_q   <= skid_a3_d;
            skid_tnew_q <= skid_tnew_d;
        end
    end

    // Bubbles must never forward or stall, so every field is masked when invalid.
    assign bus.out_valid = (state_q != EMPTY);
    assign bus.in_ready  = (state_q != TWO);
    assign bus.out_data  = bus.out_valid ? main_data_q : '0;
    assign bus.out_a3    = bus.out_valid ? main_a3_q : '0;
    assign bus.out_tnew  = bus.out_valid ? main_tnew_q : '0;

    always_comb begin
        occupancy = 2'd0;
        unique case (state_q)
            EMPTY:   occupancy = 2'd0;
            ONE:     occupancy = 2'd1;
            TWO:     occupancy = 2'd2;
            default: occupancy = 2'd0;
        endcase
    end

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// Directed bench for pipe_stage_skid_reg: reset, streaming, backpressure, flush, tnew ageing.
// Expectations follow PIPE_STAGE_TNEW_AGE_EN when it is defined.
module tb_pipe_stage_skid_reg;

    localparam int DW  = 128;
    localparam int TW  = 2;
    localparam int A3W = 5;

    logic       clk;
    logic       reset;
    logic       flush;
    logic [1:0] occupancy;
    int         checks;
    int         failures;

    pipe_stage_skid_reg_if #(.DW(DW), .TW(TW), .A3W(A3W)) bus ();

    pipe_stage_skid_reg #(.DW(DW), .TW(TW), .A3W(A3W)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .bus       (bus.slave),
        .occupancy (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic offer(input logic v, input logic [127:0] d,
                         input logic [4:0] a3, input logic [1:0] tn);
        bus.in_valid = v;
        bus.in_data  = d;
        bus.in_a3    = a3;
        bus.in_tnew  = tn;
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".valid"}, 128'(bus.out_valid), 128'd0);
        check({tag, ".data"}, bus.out_data, 128'd0);
        check({tag, ".a3"}, 128'(bus.out_a3), 128'd0);
        check({tag, ".tnew"}, 128'(bus.out_tnew), 128'd0);
        check({tag, ".occ"}, 128'(occupancy), 128'd0);
        check({tag, ".in_ready"}, 128'(bus.in_ready), 128'd1);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b0;
        flush    = 1'b0;
        bus.out_ready = 1'b0;
        offer(1'b0, 128'd0, 5'd0, 2'd0);
        #1;

        // Reset for two cycles, then first capture
        step();
        step();
        check_idle("reset");
        reset = 1'b1;
        bus.out_ready = 1'b1;
        offer(1'b1, 128'h55, 5'd5, 2'd2);
        check_idle("pre_cap");
        step();
        check("cap.valid", 128'(bus.out_valid), 128'd1);
        check("cap.a3", 128'(bus.out_a3), 128'd5);
        check("cap.tnew", 128'(bus.out_tnew), 128'd1);
        check("cap.data", bus.out_data, 128'h55);
        check("cap.occ", 128'(occupancy), 128'd1);
        offer(1'b0, 128'd0, 5'd0, 2'd0);
        step();
        check_idle("drain");

        // Stream 8 entries at full rate
        for (int i = 0; i < 8; i++) begin
            offer(1'b1, 128'(i), 5'(i + 1), 2'd0);
            check("stream.in_ready", 128'(bus.in_ready), 128'd1);
            step();
            check("stream.valid", 128'(bus.out_valid), 128'd1);
            check("stream.data", bus.out_data, 128'(i));
            check("stream.a3", 128'(bus.out_a3), 128'(i + 1));
            check("stream.tnew", 128'(bus.out_tnew), 128'd0);
        end
        offer(1'b0, 128'd0, 5'd0, 2'd0);
        step();
        check("stream.end", 128'(bus.out_valid), 128'd0);

        // Backpressure: A and B fill the stage, C waits upstream
        bus.out_ready = 1'b0;
        offer(1'b1, 128'hA, 5'd1, 2'd1);
        step();
        check("bp.occ1", 128'(occupancy), 128'd1);
        offer(1'b1, 128'hB, 5'd2, 2'd3);
        step();
        check("bp.occ2", 128'(occupancy), 128'd2);
        check("bp.in_ready", 128'(bus.in_ready), 128'd0);
        check("bp.dataA", bus.out_data, 128'hA);
        offer(1'b1, 128'hC, 5'd3, 2'd2);
        step();
        check("bp.hold_occ", 128'(occupancy), 128'd2);
        check("bp.hold_data", bus.out_data, 128'hA);
        check("bp.tnewA", 128'(bus.out_tnew), 128'd0);
        bus.out_ready = 1'b1;
        step();
        check("bp.dataB", bus.out_data, 128'hB);
        check("bp.a3B", 128'(bus.out_a3), 128'd2);
`ifdef PIPE_STAGE_TNEW_AGE_EN
        check("bp.tnewB", 128'(bus.out_tnew), 128'd0);
`else
        check("bp.tnewB", 128'(bus.out_tnew), 128'd2);
`endif
        check("bp.occB", 128'(occupancy), 128'd1);
        check("bp.in_readyB", 128'(bus.in_ready), 128'd1);
        step();
        check("bp.dataC", bus.out_data, 128'hC);
        check("bp.a3C", 128'(bus.out_a3), 128'd3);
        check("bp.tnewC", 128'(bus.out_tnew), 128'd1);
        offer(1'b0, 128'd0, 5'd0, 2'd0);
        step();
        check_idle("bp.end");

        // Flush while full with an entry offered
        bus.out_ready = 1'b0;
        offer(1'b1, 128'hD, 5'd4, 2'd1);
        step();
        offer(1'b1, 128'hE, 5'd6, 2'd1);
        step();
        check("fl.occ", 128'(occupancy), 128'd2);
        offer(1'b1, 128'hF, 5'd8, 2'd1);
        flush = 1'b1;
        step();
        check_idle("flush");
        flush = 1'b0;
        offer(1'b0, 128'd0, 5'd0, 2'd0);
        bus.out_ready = 1'b1;
        step();
        check("fl.after", 128'(bus.out_valid), 128'd0);

        // Flush in ONE keeps in_ready high through the flush cycle
        bus.out_ready = 1'b0;
        offer(1'b1, 128'h11, 5'd2, 2'd1);
        step();
        flush = 1'b1;
        offer(1'b1, 128'h12, 5'd3, 2'd1);
        check("fl1.in_ready", 128'(bus.in_ready), 128'd1);
        step();
        flush = 1'b0;
        offer(1'b0, 128'd0, 5'd0, 2'd0);
        check_idle("flush1");

        // Reset beats flush and a simultaneous input
        offer(1'b1, 128'h66, 5'd7, 2'd3);
        step();
        check("rst.occ1", 128'(occupancy), 128'd1);
        reset = 1'b0;
        flush = 1'b1;
        offer(1'b1, 128'h77, 5'd9, 2'd2);
        step();
        check_idle("rst_mid");
        reset = 1'b1;
        flush = 1'b0;
        offer(1'b0, 128'd0, 5'd0, 2'd0);

        // tnew ageing while stalled
        bus.out_ready = 1'b0;
        offer(1'b1, 128'h99, 5'd9, 2'd3);
        step();
        check("age.t0", 128'(bus.out_tnew), 128'd2);
        offer(1'b0, 128'd0, 5'd0, 2'd0);
        step();
`ifdef PIPE_STAGE_TNEW_AGE_EN
        check("age.t1", 128'(bus.out_tnew), 128'd1);
        step();
        check("age.t2", 128'(bus.out_tnew), 128'd0);
        step();
        check("age.t3", 128'(bus.out_tnew), 128'd0);
`else
        check("age.t1", 128'(bus.out_tnew), 128'd2);
        step();
        check("age.t2", 128'(bus.out_tnew), 128'd2);
        step();
        check("age.t3", 128'(bus.out_tnew), 128'd2);
`endif
        check("age.data", bus.out_data, 128'h99);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
